// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_pipe
// Description : Two-stage pipelined IEEE-754 multiplier for any 1-E-M format,
//               with round-to-nearest-even, flush-to-zero and exception flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_pipe #(
  parameter int  EXP_BITS  = 5,
  parameter int  MAN_BITS  = 10,
  parameter int  TAG_WIDTH = 4,
  localparam int WIDTH     = 1 + EXP_BITS + MAN_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [1:0][WIDTH-1:0] operands_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WIDTH-1:0]      result_o,
  output logic [3:0]            status_o,
  output logic [TAG_WIDTH-1:0]  tag_o
);

  localparam int BIAS = 2 ** (EXP_BITS - 1) - 1;
  localparam int PW   = 2 * MAN_BITS + 2;
  localparam int EW   = EXP_BITS + 2;

  localparam logic [EW-1:0]       C_BIAS     = EW'(BIAS);
  localparam logic [EW-2:0]       C_EXP_MAX  = (EW-1)'(2 ** EXP_BITS - 1);
  localparam logic [EXP_BITS-1:0] C_EXP_ONES = '1;
  localparam logic [WIDTH-1:0]    C_QNAN     = {1'b0, C_EXP_ONES, 1'b1, {(MAN_BITS-1){1'b0}}};

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic r_v1;
  logic r_v2;
  logic w_en1;
  logic w_en2;

  assign w_en2      = !r_v2 | out_ready_i;
  assign w_en1      = !r_v1 | w_en2;
  assign in_ready_o = w_en1;

  // --------------------------------------------------------------------------
  // Stage 1: operand classification, exponent sum, mantissa product
  // --------------------------------------------------------------------------
  logic [1:0]          w_sign;
  logic [1:0]          w_zero;
  logic [1:0]          w_inf;
  logic [1:0]          w_nan;
  logic [1:0]          w_snan;
  logic [EXP_BITS-1:0] w_exp [2];
  logic [MAN_BITS-1:0] w_man [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    assign w_sign[gi] = operands_i[gi][WIDTH-1];
    assign w_exp[gi]  = operands_i[gi][WIDTH-2 -: EXP_BITS];
    assign w_man[gi]  = operands_i[gi][MAN_BITS-1:0];
    // Subnormals land here too and are treated as zero.
    assign w_zero[gi] = (w_exp[gi] == '0);
    assign w_inf[gi]  = (w_exp[gi] == C_EXP_ONES) && (w_man[gi] == '0);
    assign w_nan[gi]  = (w_exp[gi] == C_EXP_ONES) && (w_man[gi] != '0);
    assign w_snan[gi] = w_nan[gi] && !w_man[gi][MAN_BITS-1];
  end

  logic          w_inf_zero;
  logic [EW-1:0] w_exp_sum;
  logic [PW-1:0] w_prod;

  assign w_inf_zero = (w_inf[1] & w_zero[0]) | (w_inf[0] & w_zero[1]);
  assign w_exp_sum  = {2'b00, w_exp[1]} + {2'b00, w_exp[0]} - C_BIAS;
  assign w_prod     = PW'({1'b1, w_man[1]}) * PW'({1'b1, w_man[0]});

  logic                 r_nan;
  logic                 r_nv;
  logic                 r_inf;
  logic                 r_zero;
  logic                 r_sign;
  logic signed [EW-1:0] r_exp_sum;
  logic [PW-1:0]        r_prod;
  logic [TAG_WIDTH-1:0] r_tag1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_v1      <= 1'b0;
      r_nan     <= 1'b0;
      r_nv      <= 1'b0;
      r_inf     <= 1'b0;
      r_zero    <= 1'b0;
      r_sign    <= 1'b0;
      r_exp_sum <= '0;
      r_prod    <= '0;
      r_tag1    <= '0;
    end else begin
      if (w_en1) begin
        r_v1 <= in_valid_i;
      end
      if (w_en1 && in_valid_i) begin
        r_nan     <= (|w_nan) | w_inf_zero;
        r_nv      <= (|w_snan) | w_inf_zero;
        r_inf     <= |w_inf;
        r_zero    <= |w_zero;
        r_sign    <= w_sign[1] ^ w_sign[0];
        r_exp_sum <= $signed(w_exp_sum);
        r_prod    <= w_prod;
        r_tag1    <= tag_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: normalise, round to nearest even, range check, pack
  // --------------------------------------------------------------------------
  logic                 w_norm;
  logic [MAN_BITS-1:0]  w_frac;
  logic                 w_guard;
  logic                 w_sticky;
  logic                 w_round_up;
  logic                 w_carry;
  logic [MAN_BITS-1:0]  w_frac_rnd;
  logic signed [EW-1:0] w_exp_rnd;
  logic                 w_of;
  logic                 w_uf;

  // The leading one sits at bit PW-1 or PW-2; pick the window below it.
  assign w_norm     = r_prod[PW-1];
  assign w_frac     = w_norm ? r_prod[PW-2 -: MAN_BITS] : r_prod[PW-3 -: MAN_BITS];
  assign w_guard    = w_norm ? r_prod[PW-2-MAN_BITS]   : r_prod[PW-3-MAN_BITS];
  assign w_sticky   = w_norm ? (|r_prod[PW-3-MAN_BITS:0]) : (|r_prod[PW-4-MAN_BITS:0]);
  assign w_round_up = w_guard & (w_sticky | w_frac[0]);

  assign {w_carry, w_frac_rnd} = {1'b0, w_frac} + (MAN_BITS+1)'(w_round_up);

  assign w_exp_rnd = r_exp_sum
                   + $signed({{(EW-1){1'b0}}, w_norm})
                   + $signed({{(EW-1){1'b0}}, w_carry});

  assign w_of = !w_exp_rnd[EW-1] && (w_exp_rnd[EW-2:0] >= C_EXP_MAX);
  assign w_uf = w_exp_rnd[EW-1] || (w_exp_rnd == '0);

  logic [WIDTH-1:0] w_result;
  logic [3:0]       w_status;

  // Status is {NV, OF, UF, NX}; specials take priority over the range check.
  always_comb begin
    w_result = {r_sign, w_exp_rnd[EXP_BITS-1:0], w_frac_rnd};
    w_status = {3'b000, w_guard | w_sticky};
    if (r_nan) begin
      w_result = C_QNAN;
      w_status = {r_nv, 3'b000};
    end else if (r_inf) begin
      w_result = {r_sign, C_EXP_ONES, {MAN_BITS{1'b0}}};
      w_status = 4'b0000;
    end else if (r_zero) begin
      w_result = {r_sign, {(WIDTH-1){1'b0}}};
      w_status = 4'b0000;
    end else if (w_of) begin
      w_result = {r_sign, C_EXP_ONES, {MAN_BITS{1'b0}}};
      w_status = 4'b0101;
    end else if (w_uf) begin
      w_result = {r_sign, {(WIDTH-1){1'b0}}};
      w_status = 4'b0011;
    end
  end

  logic [WIDTH-1:0]     r_result;
  logic [3:0]           r_status;
  logic [TAG_WIDTH-1:0] r_tag2;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_v2     <= 1'b0;
      r_result <= '0;
      r_status <= '0;
      r_tag2   <= '0;
    end else begin
      if (w_en2) begin
        r_v2 <= r_v1;
      end
      if (w_en2 && r_v1) begin
        r_result <= w_result;
        r_status <= w_status;
        r_tag2   <= r_tag1;
      end
    end
  end

  assign out_valid_o = r_v2;
  assign result_o    = r_result;
  assign status_o    = r_status;
  assign tag_o       = r_tag2;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mul_pipe
// Description : Self-checking bench for fp_mul_pipe in FP16, BF16 and FP32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mul_pipe;

  logic clk;
  logic rst;
  logic in_valid;
  logic out_ready;
  logic [3:0] tag;

  logic [1:0][15:0] ops16;
  logic [1:0][15:0] opsbf;
  logic [1:0][31:0] ops32;

  logic        rdy16, rdybf, rdy32;
  logic        vld16, vldbf, vld32;
  logic [15:0] res16, resbf;
  logic [31:0] res32;
  logic [3:0]  st16, stbf, st32;
  logic [3:0]  tag16, tagbf, tag32;

  fp_mul_pipe u_fp16 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy16),
    .operands_i(ops16), .tag_i(tag), .out_valid_o(vld16), .out_ready_i(out_ready),
    .result_o(res16), .status_o(st16), .tag_o(tag16));

  fp_mul_pipe #(.EXP_BITS(8), .MAN_BITS(7)) u_bf16 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdybf),
    .operands_i(opsbf), .tag_i(tag), .out_valid_o(vldbf), .out_ready_i(out_ready),
    .result_o(resbf), .status_o(stbf), .tag_o(tagbf));

  fp_mul_pipe #(.EXP_BITS(8), .MAN_BITS(23)) u_fp32 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy32),
    .operands_i(ops32), .tag_i(tag), .out_valid_o(vld32), .out_ready_i(out_ready),
    .result_o(res32), .status_o(st32), .tag_o(tag32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  logic last_in_ready;

  typedef struct packed {
    logic [19:0] e16;
    logic [19:0] ebf;
    logic [35:0] e32;
    logic [3:0]  tag;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  // Reference: exact integer product, remainder-vs-half rounding, FTZ, {status, result}.
  function automatic logic [35:0] ref_mul(input int E, input int M,
                                          input logic [31:0] a, input logic [31:0] b);
    longint unsigned emax, bias, mmask, ea, eb, ma, mb, p, q, rem, half, sgn, qnan;
    int e, sh;
    logic an, bn, ai, bi, az, bz, nv;
    emax  = (64'd1 << E) - 1;
    bias  = (64'd1 << (E - 1)) - 1;
    mmask = (64'd1 << M) - 1;
    ea = (64'(a) >> M) & emax;  ma = 64'(a) & mmask;
    eb = (64'(b) >> M) & emax;  mb = 64'(b) & mmask;
    sgn  = (((64'(a) ^ 64'(b)) >> (E + M)) & 1) << (E + M);
    qnan = (emax << M) | (64'd1 << (M - 1));
    an = (ea == emax) && (ma != 0);  bn = (eb == emax) && (mb != 0);
    ai = (ea == emax) && (ma == 0);  bi = (eb == emax) && (mb == 0);
    az = (ea == 0);                  bz = (eb == 0);
    nv = (an && ((ma >> (M - 1)) & 1) == 0) || (bn && ((mb >> (M - 1)) & 1) == 0)
       || (ai && bz) || (bi && az);
    if (an || bn || (ai && bz) || (bi && az)) return {nv, 3'b000, 32'(qnan)};
    if (ai || bi) return {4'b0000, 32'(sgn | (emax << M))};
    if (az || bz) return {4'b0000, 32'(sgn)};
    p = ((64'd1 << M) | ma) * ((64'd1 << M) | mb);
    e = int'(ea) + int'(eb) - int'(bias);
    if (p >= (64'd1 << (2 * M + 1))) begin sh = M + 1; e++; end
    else sh = M;
    q    = p >> sh;
    rem  = p & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << (M + 1))) begin q = q >> 1; e++; end
    if (e >= int'(emax)) return {4'b0101, 32'(sgn | (emax << M))};
    if (e <= 0) return {4'b0011, 32'(sgn)};
    return {3'b000, rem != 0, 32'(sgn | (64'(e) << M) | (q & mmask))};
  endfunction

  function automatic logic [15:0] rand16();
    if ($urandom % 2) return 16'($urandom);
    return {1'($urandom), 5'(8 + $urandom % 16), 10'($urandom)};
  endfunction

  function automatic logic [15:0] randbf();
    if ($urandom % 2) return 16'($urandom);
    return {1'($urandom), 8'(112 + $urandom % 32), 7'($urandom)};
  endfunction

  function automatic logic [31:0] rand32();
    if ($urandom % 2) return $urandom;
    return {1'($urandom), 8'(112 + $urandom % 32), 23'($urandom)};
  endfunction

  // One clock cycle, entered and left just after a falling edge.
  task automatic cycle(input logic iv, input logic [15:0] a16, input logic [15:0] b16,
                       input logic [15:0] abf, input logic [15:0] bbf,
                       input logic [31:0] a32, input logic [31:0] b32,
                       input logic [3:0] tg, input logic ordy);
    logic fire_in, fire_out, hold;
    logic [23:0] s16, sbf;
    logic [39:0] s32;
    logic [35:0] m;
    exp_t ex;
    in_valid = iv; ops16 = {a16, b16}; opsbf = {abf, bbf}; ops32 = {a32, b32};
    tag = tg; out_ready = ordy;
    #1;
    chk("ready_lockstep", {rdybf, rdy32}, {rdy16, rdy16});
    chk("valid_lockstep", {vldbf, vld32}, {vld16, vld16});
    last_in_ready = rdy16;
    fire_in  = iv & rdy16;
    fire_out = vld16 & ordy;
    if (fire_out) begin
      chk("result_expected", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        ex = sb.pop_front();
        chk("sb_fp16", {st16, res16}, ex.e16);
        chk("sb_tag16", tag16, ex.tag);
        chk("sb_bf16", {stbf, resbf}, ex.ebf);
        chk("sb_tagbf", tagbf, ex.tag);
        chk("sb_fp32", {st32, res32}, ex.e32);
        chk("sb_tag32", tag32, ex.tag);
      end
    end
    if (fire_in) begin
      m = ref_mul(5, 10, {16'd0, a16}, {16'd0, b16});
      ex.e16 = {m[35:32], m[15:0]};
      m = ref_mul(8, 7, {16'd0, abf}, {16'd0, bbf});
      ex.ebf = {m[35:32], m[15:0]};
      ex.e32 = ref_mul(8, 23, a32, b32);
      ex.tag = tg;
      sb.push_back(ex);
      n_acc++;
    end
    hold = vld16 & !ordy;
    s16 = {st16, res16, tag16};
    sbf = {stbf, resbf, tagbf};
    s32 = {st32, res32, tag32};
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      chk("stall_valid", vld16, 1'b1);
      chk("stall_fp16", {st16, res16, tag16}, s16);
      chk("stall_bf16", {stbf, resbf, tagbf}, sbf);
      chk("stall_fp32", {st32, res32, tag32}, s32);
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0, 32'd0, 4'd0, ordy);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() > 0; k++) idle(1'b1);
    chk("drain_empty", sb.size(), 0);
    chk("drain_idle", vld16, 1'b0);
  endtask

  task automatic run_one(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] r, input logic [3:0] s, input logic [3:0] tg);
    cycle(1'b1, a, b, 16'h3FC0, 16'h3FC0, rand32(), rand32(), tg, 1'b1);
    chk("dir_accepted", last_in_ready, 1'b1);
    chk("lat_early", vld16, 1'b0);
    idle(1'b1);
    chk("lat_valid", vld16, 1'b1);
    chk("dir_result", res16, r);
    chk("dir_status", st16, s);
    chk("dir_tag", tag16, tg);
    chk("bf16_result", resbf, 16'h4010);
    chk("bf16_status", stbf, 4'b0000);
    idle(1'b1);
  endtask

  logic [15:0] dir_a [12];
  logic [15:0] dir_b [12];
  logic [15:0] dir_r [12];
  logic [3:0]  dir_s [12];

  initial begin
    dir_a = '{16'h3E00, 16'h3C01, 16'h3C01, 16'h7BFF, 16'h0400, 16'hFBFF,
              16'h7C00, 16'h7D00, 16'hFC00, 16'h8000, 16'h0001, 16'h7E00};
    dir_b = '{16'h3E00, 16'h3C01, 16'h3E00, 16'h4000, 16'h3800, 16'h4000,
              16'h0000, 16'h3C00, 16'h4000, 16'h3C00, 16'h3C00, 16'h3C00};
    dir_r = '{16'h4080, 16'h3C02, 16'h3E02, 16'h7C00, 16'h0000, 16'hFC00,
              16'h7E00, 16'h7E00, 16'hFC00, 16'h8000, 16'h0000, 16'h7E00};
    dir_s = '{4'b0000, 4'b0001, 4'b0001, 4'b0101, 4'b0011, 4'b0101,
              4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; tag = '0;
    ops16 = '0; opsbf = '0; ops32 = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", vld16, 1'b0);
    chk("rst_in_ready", rdy16, 1'b1);
    chk("rst_result16", res16, 16'd0);
    chk("rst_status16", st16, 4'd0);
    chk("rst_tag16", tag16, 4'd0);
    chk("rst_result32", res32, 32'd0);
    rst = 1'b0;
    idle(1'b1);
    chk("post_rst_ready", rdy16, 1'b1);

    for (int i = 0; i < 12; i++)
      run_one(dir_a[i], dir_b[i], dir_r[i], dir_s[i], 4'(i + 5));

    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, rand16(), rand16(), randbf(), randbf(), rand32(), rand32(),
            4'($urandom), 1'b0);
      chk("bp_in_ready", last_in_ready, i < 2);
    end
    drain();

    n_acc = 0;
    for (int k = 0; k < 400 && n_acc < 8; k++)
      cycle(($urandom % 4) != 0, rand16(), rand16(), randbf(), randbf(), rand32(), rand32(),
            4'($urandom), 1'($urandom));
    chk("stream8_count", n_acc, 8);
    drain();

    n_acc = 0;
    for (int k = 0; k < 2000 && n_acc < 80; k++)
      cycle(($urandom % 4) != 0, rand16(), rand16(), randbf(), randbf(), rand32(), rand32(),
            4'($urandom), ($urandom % 3) != 0);
    chk("stream80_count", n_acc, 80);
    drain();

    for (int i = 0; i < 3; i++)
      cycle(1'b1, rand16(), rand16(), randbf(), randbf(), rand32(), rand32(), 4'hA, 1'b0);
    chk("pre_rst_valid", vld16, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", vld16, 1'b0);
    chk("mid_rst_ready", rdy16, 1'b1);
    chk("mid_rst_result", res16, 16'd0);
    sb.delete();
    idle(1'b1);
    idle(1'b1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("no_stale", vld16, 1'b0);
    end
    run_one(16'h3E00, 16'h3E00, 16'h4080, 4'b0000, 4'd5);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
